// File: rtl/irq_controller.sv
// Three-source fixed-priority interrupt controller with pending/mask/ISR regs.
// Define IRQ_SYNC_EN to pass src_req through a two-flop synchronizer.
module irq_controller #(
  parameter logic [2:0] RESET_MASK = 3'b111,
  parameter bit         EDGE_MODE  = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] src_req,
  input  logic       monin,
  input  logic       cfg_we,
  input  logic [1:0] cfg_addr,
  input  logic [2:0] cfg_wdata,
  output logic [2:0] cfg_rdata,
  output logic [1:0] irq,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    SVC_CHK,
    SVC_WAIT
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] mask_q, mask_d;
  logic [2:0] pend_q, pend_d;
  logic [2:0] isr_q, isr_d;
  logic [2:0] prev_q;
  logic [1:0] irq_q, irq_d;
  logic [2:0] src_s;
  logic [2:0] rise;
  logic [2:0] cand;
  logic [2:0] win_oh;
  logic [1:0] win_code;
  logic       take;
  logic       drop;

`ifdef IRQ_SYNC_EN
  logic [2:0] sync1_q, sync2_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= src_req;
      sync2_q <= sync1_q;
    end
  end

  assign src_s = sync2_q;
`else
  assign src_s = src_req;
`endif

  assign rise = src_s & ~prev_q;
  assign cand = pend_q & mask_q;

  always_comb begin
    win_oh   = '0;
    win_code = '0;
    priority case (1'b1)
      cand[0]: begin win_oh = 3'b001; win_code = 2'b01; end
      cand[1]: begin win_oh = 3'b010; win_code = 2'b10; end
      cand[2]: begin win_oh = 3'b100; win_code = 2'b11; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      isr_q   <= '0;
      irq_q   <= '0;
    end else begin
      state_q <= state_d;
      isr_q   <= isr_d;
      irq_q   <= irq_d;
    end
  end

  always_comb begin
    state_d = state_q;
    isr_d   = isr_q;
    take    = 1'b0;
    drop    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|cand && !monin) begin
          state_d = ISSUE;
          isr_d   = win_oh;
          take    = 1'b1;
        end
      end
      ISSUE: state_d = SVC_CHK;
      SVC_CHK: begin
        if (monin) begin
          state_d = SVC_WAIT;
        end else begin
          // CPU never entered the handler: hand the source back to pend
          state_d = IDLE;
          isr_d   = '0;
          drop    = 1'b1;
        end
      end
      SVC_WAIT: begin
        if (!monin) begin
          state_d = IDLE;
          isr_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    irq_d = take ? win_code : 2'b00;
    busy  = (state_q != IDLE);
  end

  assign irq = irq_q;

  always_comb begin
    mask_d = mask_q;
    if (cfg_we && cfg_addr == 2'd0) begin
      mask_d = cfg_wdata;
    end
  end

  always_comb begin
    pend_d = pend_q;
    if (EDGE_MODE) begin
      if (cfg_we && cfg_addr == 2'd1) begin
        pend_d = pend_d & ~cfg_wdata;
      end
      if (take) begin
        pend_d = pend_d & ~win_oh;
      end
      if (drop) begin
        pend_d = pend_d | isr_q;
      end
      // new edges win over every clear source
      pend_d = pend_d | rise;
    end else begin
      pend_d = src_s;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mask_q <= RESET_MASK;
      pend_q <= '0;
      prev_q <= '0;
    end else begin
      mask_q <= mask_d;
      pend_q <= pend_d;
      prev_q <= src_s;
    end
  end

  always_comb begin
    cfg_rdata = '0;
    unique case (cfg_addr)
      2'd0:    cfg_rdata = mask_q;
      2'd1:    cfg_rdata = pend_q;
      2'd2:    cfg_rdata = isr_q;
      default: cfg_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller: latency, priority, mask,
// dropped vector, kernel blocking, W1C collision, async reset.
module tb_irq_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] src_req;
  logic       monin;
  logic       cfg_we;
  logic [1:0] cfg_addr;
  logic [2:0] cfg_wdata;
  logic [2:0] cfg_rdata;
  logic [1:0] irq;
  logic       busy;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  irq_controller #(
    .RESET_MASK(3'b111),
    .EDGE_MODE (1'b1)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .src_req  (src_req),
    .monin    (monin),
    .cfg_we   (cfg_we),
    .cfg_addr (cfg_addr),
    .cfg_wdata(cfg_wdata),
    .cfg_rdata(cfg_rdata),
    .irq      (irq),
    .busy     (busy)
  );

  task automatic check(input string tag,
                       input logic [7:0] got,
                       input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reg(input string tag,
                         input logic [1:0] a,
                         input logic [2:0] exp);
    cfg_addr = a;
    #1;
    check(tag, {5'b0, cfg_rdata}, {5'b0, exp});
  endtask

  task automatic wr(input logic [1:0] a, input logic [2:0] d);
    cfg_we    = 1'b1;
    cfg_addr  = a;
    cfg_wdata = d;
    tick();
    cfg_we    = 1'b0;
    cfg_wdata = '0;
  endtask

  // CPU model, entered in the first SERVICE cycle; returns in IDLE
  task automatic svc();
    monin = 1'b1;
    repeat (3) tick();
    monin = 1'b0;
    tick();
  endtask

  logic prev_nz = 1'b0;
  always @(negedge clk) begin
    check("irq_single", {7'b0, prev_nz & (irq != 2'b00)}, 8'h0);
    prev_nz <= (irq != 2'b00);
  end

  initial begin
    reset     = 1'b0;
    src_req   = '0;
    monin     = 1'b0;
    cfg_we    = 1'b0;
    cfg_addr  = '0;
    cfg_wdata = '0;
    repeat (3) tick();
    check("rst_irq", {6'b0, irq}, 8'h0);
    check("rst_busy", {7'b0, busy}, 8'h0);
    chk_reg("rst_mask", 2'd0, 3'b111);
    chk_reg("rst_pend", 2'd1, 3'b000);
    chk_reg("rst_isr", 2'd2, 3'b000);
    chk_reg("rd_addr3", 2'd3, 3'b000);
    reset = 1'b1;
    repeat (5) tick();

    // single timer pulse, long handler
    src_req = 3'b001;
    tick();
    src_req = '0;
    chk_reg("t1_pend", 2'd1, 3'b001);
    check("t1_irq_n1", {6'b0, irq}, 8'h0);
    tick();
    check("t1_irq_n2", {6'b0, irq}, 8'h1);
    check("t1_busy_n2", {7'b0, busy}, 8'h1);
    tick();
    check("t1_irq_n3", {6'b0, irq}, 8'h0);
    check("t1_busy_n3", {7'b0, busy}, 8'h1);
    chk_reg("t1_isr", 2'd2, 3'b001);
    chk_reg("t1_pend_clr", 2'd1, 3'b000);
    monin = 1'b1;
    repeat (5) tick();
    check("t1_busy_hold", {7'b0, busy}, 8'h1);
    monin = 1'b0;
    tick();
    check("t1_busy_done", {7'b0, busy}, 8'h0);
    chk_reg("t1_pend_end", 2'd1, 3'b000);
    chk_reg("t1_isr_end", 2'd2, 3'b000);

    // simultaneous RX + TX
    src_req = 3'b110;
    tick();
    src_req = '0;
    chk_reg("sim_pend", 2'd1, 3'b110);
    tick();
    check("sim_irq_rx", {6'b0, irq}, 8'h2);
    tick();
    monin = 1'b1;
    check("sim_irq_svc", {6'b0, irq}, 8'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("sim_hold", {6'b0, irq}, 8'h0);
    end
    monin = 1'b0;
    tick();
    check("sim_idle_irq", {6'b0, irq}, 8'h0);
    check("sim_idle_busy", {7'b0, busy}, 8'h0);
    chk_reg("sim_pend_tx", 2'd1, 3'b100);
    tick();
    check("sim_irq_tx", {6'b0, irq}, 8'h3);
    tick();
    svc();
    check("sim_end_busy", {7'b0, busy}, 8'h0);
    chk_reg("sim_end_pend", 2'd1, 3'b000);

    // masked TX stays pending until unmasked
    wr(2'd0, 3'b011);
    src_req = 3'b100;
    tick();
    src_req = '0;
    chk_reg("msk_pend", 2'd1, 3'b100);
    tick();
    check("msk_irq_a", {6'b0, irq}, 8'h0);
    tick();
    check("msk_irq_b", {6'b0, irq}, 8'h0);
    check("msk_busy", {7'b0, busy}, 8'h0);
    wr(2'd0, 3'b111);
    check("msk_irq_w1", {6'b0, irq}, 8'h0);
    tick();
    check("msk_irq_w2", {6'b0, irq}, 8'h3);
    tick();
    svc();
    check("msk_end_busy", {7'b0, busy}, 8'h0);

    // dropped vector re-issues
    src_req = 3'b010;
    tick();
    src_req = '0;
    tick();
    check("drp_irq1", {6'b0, irq}, 8'h2);
    tick();
    check("drp_irq_svc", {6'b0, irq}, 8'h0);
    chk_reg("drp_isr", 2'd2, 3'b010);
    tick();
    chk_reg("drp_pend_reset", 2'd1, 3'b010);
    chk_reg("drp_isr_clr", 2'd2, 3'b000);
    check("drp_busy", {7'b0, busy}, 8'h0);
    tick();
    check("drp_irq2", {6'b0, irq}, 8'h2);
    tick();
    svc();
    check("drp_end_busy", {7'b0, busy}, 8'h0);

    // kernel blocking
    monin   = 1'b1;
    src_req = 3'b001;
    tick();
    src_req = '0;
    chk_reg("krn_pend", 2'd1, 3'b001);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("krn_irq_blk", {6'b0, irq}, 8'h0);
      check("krn_busy_blk", {7'b0, busy}, 8'h0);
    end
    monin = 1'b0;
    tick();
    check("krn_irq", {6'b0, irq}, 8'h1);
    tick();
    svc();
    check("krn_end_busy", {7'b0, busy}, 8'h0);

    // W1C colliding with a new edge
    monin   = 1'b1;
    src_req = 3'b001;
    tick();
    src_req = '0;
    chk_reg("w1c_pend0", 2'd1, 3'b001);
    tick();
    src_req = 3'b001;
    wr(2'd1, 3'b001);
    src_req = '0;
    chk_reg("w1c_set_wins", 2'd1, 3'b001);
    wr(2'd1, 3'b001);
    chk_reg("w1c_clear", 2'd1, 3'b000);
    monin = 1'b0;
    tick();
    check("w1c_irq", {6'b0, irq}, 8'h0);

    // async reset in the middle of SERVICE
    wr(2'd0, 3'b001);
    src_req = 3'b001;
    tick();
    src_req = '0;
    tick();
    check("rs_irq", {6'b0, irq}, 8'h1);
    tick();
    monin   = 1'b1;
    src_req = 3'b100;
    tick();
    src_req = '0;
    tick();
    chk_reg("rs_pend_pre", 2'd1, 3'b100);
    check("rs_busy_pre", {7'b0, busy}, 8'h1);
    reset = 1'b0;
    #1;
    check("rs_busy", {7'b0, busy}, 8'h0);
    check("rs_irq0", {6'b0, irq}, 8'h0);
    chk_reg("rs_mask", 2'd0, 3'b111);
    chk_reg("rs_pend", 2'd1, 3'b000);
    chk_reg("rs_isr", 2'd2, 3'b000);
    monin = 1'b0;
    tick();
    reset = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/irq_controller.md
Name: irq_controller

Overview:
- Collects three interrupt sources (timer, UART-RX, UART-TX), latches them as pending and applies a software enable mask.
- Arbitrates by fixed priority and issues a single-cycle 2-bit interrupt code to the CPU control unit: 01 timer, 10 UART-RX, 11 UART-TX, 00 none.
- Tracks the in-service interrupt until the handler returns (supervisor bit monin drops) and blocks further issue until then.
- Sits between the peripherals and the control unit's IRQ input; registers are accessed over the peripheral bus.

Parameters:
- RESET_MASK, 3'b111, enable mask value loaded at reset (bit0 timer, bit1 RX, bit2 TX).
- EDGE_MODE, 1, 1 = rising edge of src_req sets pending; 0 = pending mirrors src_req level each cycle.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- src_req  in  3  interrupt requests: bit0 timer, bit1 RX, bit2 TX
- monin  in  1  CPU supervisor bit (PC[31]); 1 = in kernel/handler
- cfg_we  in  1  register write strobe
- cfg_addr  in  2  register select: 0 MASK, 1 PEND, 2 ISR
- cfg_wdata  in  3  write data
- cfg_rdata  out  3  read data, combinational from cfg_addr
- irq  out  2  interrupt code to the control unit
- busy  out  1  1 while in ISSUE or SERVICE

Behaviour:
- Reset (reset=0, async):
  - irq=00, busy=0, state=IDLE.
  - mask=RESET_MASK, pend=000, isr=000, previous-sample register=000.
- Register writes:
  - MASK: read/write.
  - PEND: write-1-to-clear; no effect when EDGE_MODE=0.
  - ISR: read-only one-hot in-service source; writes ignored.
  - addr 3 reads 000; writes ignored.
- Pending update:
  - EDGE_MODE=1: pend[i] is set on src_req[i]&~prev[i].
  - Set beats W1C clear and arbitration clear in the same cycle.
  - Masked sources still set pend but are never issued.
- Arbitration:
  - cand = pend & mask.
  - Priority is timer > RX > TX.
- State machine:
  - IDLE, issue condition: cand!=0 and monin=0. Latch winner into isr, clear its pend bit, go to ISSUE.
  - IDLE, no issue: if monin=1 (kernel code running), no issue; stay in IDLE.
  - ISSUE: irq=code of isr for exactly this one cycle; go to SERVICE.
  - SERVICE, normal path: irq=00. If monin=1 in the first SERVICE cycle, wait for monin=0, then clear isr and go to IDLE.
  - SERVICE, dropped interrupt: if monin=0 in the first SERVICE cycle, the CPU did not take the vector. Re-set the pend bit of isr, clear isr, go to IDLE, and re-arbitrate next cycle.
  - busy=1 in ISSUE and SERVICE.
- Latency:
  - src_req edge at cycle N: pend visible at N+1.
  - irq driven at N+2 (IDLE decision at N+1, registered irq).
- Output timing: irq is a registered output and is never nonzero for two consecutive cycles.
- Mask change:
  - Clearing a mask bit during ISSUE/SERVICE does not cancel the in-service interrupt.
  - The change affects the next arbitration only.
- Simultaneous: multiple sources are issued one per service cycle in priority order. Lower ones stay pending.
- EDGE_MODE=0:
  - pend=src_req each cycle.
  - A level still high after service re-issues once the FSM returns to IDLE.

Optional Feature:
- IRQ_SYNC_EN defined: src_req passes through a two-flop synchronizer before edge detection. Pending and irq latency increase by 2 cycles (irq at N+4). Synchronizer flops reset to 0.
- Not defined: src_req is sampled directly and must be synchronous to clk.

Test Plan:
- Reset with RESET_MASK=111:
  - Stimulus: pulse src_req=001 at cycle 10, monin=0.
  - Required: irq=01 at cycle 12 only, busy=1.
  - Then drive monin=1 for 5 cycles, then 0: busy=0 the cycle after monin falls, pend=000.
- Simultaneous requests:
  - Stimulus: src_req=110 in one cycle; CPU model sets monin=1 for 3 cycles after each issue.
  - Required: irq=10 first, then 11 after the first service completes; never 01.
- Mask:
  - Stimulus: write MASK=011, then pulse TX.
  - Required: PEND reads 100, irq stays 00.
  - Then write MASK=111: irq=11 two cycles later.
- Dropped interrupt:
  - Stimulus: hold monin=0 after the ISSUE cycle.
  - Required: pend bit re-set, irq reissued with the same code 2 cycles later.
- Kernel blocking:
  - Stimulus: monin=1 while a timer edge arrives.
  - Required: no issue while monin=1; irq=01 one cycle after monin falls.
- W1C vs set collision:
  - Stimulus: write PEND=001 in the same cycle as a timer edge.
  - Required: pend bit0 stays 1.
  - Stimulus: assert reset mid-SERVICE.
  - Required: all registers return to reset values immediately.
